// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude block: kernel coefficients,
// window element type, pipeline tag and output-width derivation.
package sobel_pkg;

    // Growth needed by a 3x3 Sobel sum of unsigned pixels (sign + x4 weight).
    localparam int GUARD_BITS     = 3;
    localparam int MAX_DATA_WIDTH = 32;

    // Window elements are stored zero-extended; unused upper bits are constant.
    typedef logic [MAX_DATA_WIDTH-1:0] win_elem_t;
    typedef logic signed [2:0]         coeff_t;

    // Indexed [row][col]: row 0 is the oldest line (top), col 0 the oldest pixel (left).
    localparam coeff_t KX [3][3] = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };

    localparam coeff_t KY [3][3] = '{
        '{-3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1}
    };

    typedef struct packed {
        logic valid;
        logic eof;
    } tag_t;

    function automatic int out_width(input int data_width);
        return data_width + GUARD_BITS;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-depth delay line: o_data is the sample written DEPTH enables ago.
// Only advances on i_en so pipeline bubbles and stalls do not disturb it.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 640
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] taps [DEPTH];

    // NOTE: line storage has no reset; stale contents are never emitted because
    // output generation restarts from row 0 after reset or resync.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            taps[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign o_data = taps[DEPTH-1];

endmodule

// File: rtl/sobel_magnitude.sv
// Streaming 3x3 Sobel |Gx|+|Gy| with ready/valid flow control and frame tracking.
// Optional SOBEL_THRESH_EN adds i_thresh and binarises o_mag against it.
module sobel_magnitude
    import sobel_pkg::*;
#(
    parameter  int DATA_WIDTH = 12,
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    localparam int OUT_WIDTH  = out_width(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_mag,
    output logic                  o_eof,
`ifdef SOBEL_THRESH_EN
    input  logic [OUT_WIDTH-1:0]  i_thresh,
`endif
    output logic                  o_sync_err
);

    localparam int SUM_W = DATA_WIDTH + GUARD_BITS;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic adv;
    logic accept;

    logic [COL_W-1:0] col_q, pix_col, col_d;
    logic [ROW_W-1:0] row_q, pix_row, row_d;
    logic             emit;
    logic             last_pix;
    logic             sync_hit;

    logic [DATA_WIDTH-1:0] line1;
    logic [DATA_WIDTH-1:0] line2;
    win_elem_t             win [3][3];

    tag_t                    w_tag;
    tag_t                    g_tag;
    logic signed [SUM_W-1:0] gx_c, gy_c;
    logic signed [SUM_W-1:0] gx_q, gy_q;
    logic [OUT_WIDTH-1:0]    mag_c;
    logic [OUT_WIDTH-1:0]    mag_out;

    // One global advance: the whole pipeline freezes while the output is blocked.
    assign adv     = !o_valid || i_ready;
    assign accept  = i_valid && adv;
    assign o_ready = adv;

    // Position of the pixel on the input bus, and where the counters go next.
    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path infers a latch.
        pix_col = col_q;
        pix_row = row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (i_sof) begin
            pix_col = '0;
            pix_row = '0;
        end
        if (pix_col == COL_LAST) begin
            col_d = '0;
            row_d = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
        end else begin
            col_d = pix_col + 1'b1;
            row_d = pix_row;
        end
    end

    assign emit     = (pix_row >= ROW_FIRST) && (pix_col >= COL_FIRST);
    assign last_pix = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    assign sync_hit = i_sof && ((col_q != '0) || (row_q != '0));

    // NOTE: clocked state uses <= throughout; = is reserved for combinational logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            o_sync_err <= 1'b0;
        end else begin
            o_sync_err <= accept && sync_hit;
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    sobel_line_buffer #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_WIDTH)
    ) u_line_near (
        .i_clk  (i_clk),
        .i_en   (accept),
        .i_data (i_pixel),
        .o_data (line1)
    );

    sobel_line_buffer #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_WIDTH)
    ) u_line_far (
        .i_clk  (i_clk),
        .i_en   (accept),
        .i_data (line1),
        .o_data (line2)
    );

    // Newest pixel enters at column 2 (right edge of the kernel).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= win_elem_t'(line2);
            win[1][2] <= win_elem_t'(line1);
            win[2][2] <= win_elem_t'(i_pixel);
        end
    end

    always_comb begin
        gx_c = '0;
        gy_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx_c = gx_c + SUM_W'(KX[r][c]) * $signed(SUM_W'(win[r][c]));
                gy_c = gy_c + SUM_W'(KY[r][c]) * $signed(SUM_W'(win[r][c]));
            end
        end
    end

    // Tags advance with adv so a stalled window result is not lost or duplicated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_tag <= '0;
            g_tag <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
        end else if (adv) begin
            w_tag.valid <= accept && emit;
            w_tag.eof   <= last_pix;
            g_tag       <= w_tag;
            gx_q        <= gx_c;
            gy_q        <= gy_c;
        end
    end

    function automatic logic [OUT_WIDTH-1:0] abs_val(input logic signed [SUM_W-1:0] v);
        return v[SUM_W-1] ? OUT_WIDTH'(-v) : OUT_WIDTH'(v);
    endfunction

    assign mag_c = abs_val(gx_q) + abs_val(gy_q);

`ifdef SOBEL_THRESH_EN
    assign mag_out = {OUT_WIDTH{mag_c >= i_thresh}};
`else
    assign mag_out = mag_c;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_mag   <= '0;
            o_eof   <= 1'b0;
        end else if (adv) begin
            o_valid <= g_tag.valid;
            o_mag   <= mag_out;
            o_eof   <= g_tag.valid && g_tag.eof;
        end
    end

endmodule
